// File: rtl/bus_cycle_sequencer.sv
// Eight-phase bus cycle sequencer: drives a 12-bit fetch address as three
// nibbles, captures the opcode nibbles, and strobes the ROM/RAM commands.
module bus_cycle_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        halt,
    input  logic [11:0] pc,
    input  logic        two_word,
    input  logic        io_op,
    input  logic        x_drive,
    input  logic [3:0]  x_data,
    input  logic [3:0]  data_i,
    output logic [3:0]  data_o,
    output logic        data_en,
    output logic        sync,
    output logic        rom_cmd,
    output logic        ram_cmd_n,
    output logic [3:0]  opr,
    output logic [3:0]  opa,
    output logic        instr_valid,
    output logic        second_word,
    output logic [2:0]  phase
);

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } state_t;

    state_t      state;
    state_t      next;
    logic [11:0] addr_reg;

    // Address and second-word flag are only taken when leaving X3 for A1.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= X3;
            addr_reg    <= '0;
            opr         <= '0;
            opa         <= '0;
            second_word <= 1'b0;
        end else begin
            state <= next;
            if (state == X3 && !halt) begin
                addr_reg    <= pc;
                second_word <= two_word;
            end
            if (state == M1)
                opr <= data_i;
            if (state == M2)
                opa <= data_i;
        end
    end

    always_comb begin
        next        = state;
        data_o      = 4'h0;
        data_en     = 1'b0;
        sync        = 1'b0;
        rom_cmd     = 1'b0;
        ram_cmd_n   = 1'b1;
        instr_valid = 1'b0;
        unique case (state)
            A1: begin
                data_o  = addr_reg[3:0];
                data_en = 1'b1;
                next    = A2;
            end
            A2: begin
                data_o  = addr_reg[7:4];
                data_en = 1'b1;
                next    = A3;
            end
            A3: begin
                data_o  = addr_reg[11:8];
                data_en = 1'b1;
                rom_cmd = 1'b1;
                next    = M1;
            end
            M1: next = M2;
            M2: begin
                rom_cmd = io_op;
                next    = X1;
            end
            X1: begin
                instr_valid = 1'b1;
                next        = X2;
            end
            X2: begin
                if (x_drive) begin
                    data_o  = x_data;
                    data_en = 1'b1;
                end
                ram_cmd_n = ~(io_op & ~second_word);
                next      = X3;
            end
            X3: begin
                sync = 1'b1;
                next = halt ? X3 : A1;
            end
            default: next = X3;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed bench for bus_cycle_sequencer: fetch, halt, two-word,
// I/O strobes and reset aborts, each with hand-computed expectations.
module tb_bus_cycle_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        halt;
    logic [11:0] pc;
    logic        two_word;
    logic        io_op;
    logic        x_drive;
    logic [3:0]  x_data;
    logic [3:0]  data_i;
    logic [3:0]  data_o;
    logic        data_en;
    logic        sync;
    logic        rom_cmd;
    logic        ram_cmd_n;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic        instr_valid;
    logic        second_word;
    logic [2:0]  phase;

    int n_chk  = 0;
    int n_pass = 0;

    bus_cycle_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .halt        (halt),
        .pc          (pc),
        .two_word    (two_word),
        .io_op       (io_op),
        .x_drive     (x_drive),
        .x_data      (x_data),
        .data_i      (data_i),
        .data_o      (data_o),
        .data_en     (data_en),
        .sync        (sync),
        .rom_cmd     (rom_cmd),
        .ram_cmd_n   (ram_cmd_n),
        .opr         (opr),
        .opa         (opa),
        .instr_valid (instr_valid),
        .second_word (second_word),
        .phase       (phase)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_to(input logic [2:0] p);
        for (int i = 0; i < 16; i++) begin
            if (phase == p)
                break;
            step();
        end
        chk("run_to", 16'(phase), 16'(p));
    endtask

    initial begin
        reset    = 1'b0;
        halt     = 1'b0;
        pc       = 12'h000;
        two_word = 1'b0;
        io_op    = 1'b0;
        x_drive  = 1'b0;
        x_data   = 4'h0;
        data_i   = 4'h0;
        step();
        step();

        // reset state
        chk("rst_phase", 16'(phase), 16'd7);
        chk("rst_sync", 16'(sync), 16'd1);
        chk("rst_en", 16'(data_en), 16'd0);
        chk("rst_do", 16'(data_o), 16'h0);
        chk("rst_rom", 16'(rom_cmd), 16'd0);
        chk("rst_ram", 16'(ram_cmd_n), 16'd1);
        chk("rst_iv", 16'(instr_valid), 16'd0);
        chk("rst_opr", 16'(opr), 16'd0);
        chk("rst_opa", 16'(opa), 16'd0);
        chk("rst_sw", 16'(second_word), 16'd0);

        // nominal fetch
        pc    = 12'hABC;
        reset = 1'b1;
        step();
        chk("a1_phase", 16'(phase), 16'd0);
        chk("a1_do", 16'(data_o), 16'hC);
        chk("a1_en", 16'(data_en), 16'd1);
        chk("a1_sync", 16'(sync), 16'd0);
        step();
        chk("a2_do", 16'(data_o), 16'hB);
        chk("a2_en", 16'(data_en), 16'd1);
        step();
        chk("a3_do", 16'(data_o), 16'hA);
        chk("a3_rom", 16'(rom_cmd), 16'd1);
        step();
        data_i = 4'h5;
        chk("m1_phase", 16'(phase), 16'd3);
        chk("m1_en", 16'(data_en), 16'd0);
        chk("m1_iv", 16'(instr_valid), 16'd0);
        step();
        data_i = 4'h3;
        chk("m2_en", 16'(data_en), 16'd0);
        chk("m2_rom", 16'(rom_cmd), 16'd0);
        chk("m2_opr", 16'(opr), 16'h5);
        step();
        data_i = 4'h0;
        chk("x1_iv", 16'(instr_valid), 16'd1);
        chk("x1_opr", 16'(opr), 16'h5);
        chk("x1_opa", 16'(opa), 16'h3);
        step();
        chk("x2_iv", 16'(instr_valid), 16'd0);
        chk("x2_en", 16'(data_en), 16'd0);
        chk("x2_ram", 16'(ram_cmd_n), 16'd1);
        step();
        chk("x3_phase", 16'(phase), 16'd7);
        chk("x3_sync", 16'(sync), 16'd1);
        chk("x3_iv", 16'(instr_valid), 16'd0);

        // halt for three stalled X3 cycles while pc moves
        halt = 1'b1;
        pc   = 12'h010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_phase", 16'(phase), 16'd7);
            chk("halt_sync", 16'(sync), 16'd1);
            if (i == 1)
                pc = 12'h020;
        end
        halt = 1'b0;
        step();
        chk("halt_exit_phase", 16'(phase), 16'd0);
        chk("halt_exit_a1", 16'(data_o), 16'h0);
        step();
        chk("halt_exit_a2", 16'(data_o), 16'h2);
        chk("halt_opr_hold", 16'(opr), 16'h5);

        // two-word cycle
        run_to(3'd7);
        two_word = 1'b1;
        pc       = 12'h123;
        step();
        two_word = 1'b0;
        chk("tw_sw", 16'(second_word), 16'd1);
        chk("tw_a1", 16'(data_o), 16'h3);
        run_to(3'd4);
        io_op = 1'b1;
        step();
        chk("tw_iv", 16'(instr_valid), 16'd1);
        step();
        chk("tw_x2_ram", 16'(ram_cmd_n), 16'd1);
        io_op = 1'b0;
        run_to(3'd7);
        step();
        chk("tw_next_sw", 16'(second_word), 16'd0);

        // I/O strobes
        io_op   = 1'b1;
        x_drive = 1'b1;
        x_data  = 4'h9;
        chk("io_a1_rom", 16'(rom_cmd), 16'd0);
        step();
        chk("io_a2_rom", 16'(rom_cmd), 16'd0);
        step();
        chk("io_a3_rom", 16'(rom_cmd), 16'd1);
        step();
        chk("io_m1_rom", 16'(rom_cmd), 16'd0);
        chk("io_m1_en", 16'(data_en), 16'd0);
        step();
        chk("io_m2_rom", 16'(rom_cmd), 16'd1);
        step();
        chk("io_x1_ram", 16'(ram_cmd_n), 16'd1);
        chk("io_x1_en", 16'(data_en), 16'd0);
        step();
        chk("io_x2_ram", 16'(ram_cmd_n), 16'd0);
        chk("io_x2_do", 16'(data_o), 16'h9);
        chk("io_x2_en", 16'(data_en), 16'd1);
        step();
        chk("io_x3_ram", 16'(ram_cmd_n), 16'd1);
        chk("io_x3_en", 16'(data_en), 16'd0);
        chk("io_x3_do", 16'(data_o), 16'h0);
        io_op   = 1'b0;
        x_drive = 1'b0;

        // reset abort in M2
        step();
        run_to(3'd3);
        data_i = 4'h7;
        step();
        chk("mr_opr", 16'(opr), 16'h7);
        data_i = 4'hE;
        io_op  = 1'b1;
        reset  = 1'b0;
        step();
        io_op = 1'b0;
        chk("mr_phase", 16'(phase), 16'd7);
        chk("mr_opr0", 16'(opr), 16'h0);
        chk("mr_opa0", 16'(opa), 16'h0);
        chk("mr_en", 16'(data_en), 16'd0);
        chk("mr_ram", 16'(ram_cmd_n), 16'd1);
        chk("mr_sync", 16'(sync), 16'd1);
        chk("mr_iv", 16'(instr_valid), 16'd0);
        data_i = 4'h0;

        // reset takes precedence over a cleared halt
        step();
        chk("rst_prec", 16'(phase), 16'd7);

        // reset while stalled in X3
        reset = 1'b1;
        halt  = 1'b1;
        pc    = 12'hFFF;
        step();
        chk("rh_stall", 16'(phase), 16'd7);
        reset = 1'b0;
        step();
        chk("rh_phase", 16'(phase), 16'd7);
        chk("rh_sync", 16'(sync), 16'd1);
        reset = 1'b1;
        halt  = 1'b0;
        pc    = 12'h456;
        step();
        chk("rh_a1", 16'(phase), 16'd0);
        chk("rh_a1_do", 16'(data_o), 16'h6);
        step();
        chk("rh_a2_do", 16'(data_o), 16'h5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_cycle_sequencer.md
BUS_CYCLE_SEQUENCER -- requirements
Module: bus_cycle_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-003 SHALL have port: halt  input  1  stall request; sampled only in X3.
REQ-004 SHALL have port: pc  input  12  fetch address from datapath.
REQ-005 SHALL have port: two_word  input  1  decoder flag; next cycle fetches second instruction word.
REQ-006 SHALL have port: io_op  input  1  decoder flag, valid M2..X2; current instruction is I/O.
REQ-007 SHALL have port: x_drive  input  1  datapath requests bus drive in X2.
REQ-008 SHALL have port: x_data  input  4  datapath nibble driven in X2.
REQ-009 SHALL have port: data_i  input  4  external bus nibble.
REQ-010 SHALL have port: data_o  output  4  external bus nibble out.
REQ-011 SHALL have port: data_en  output  1  bus output enable.
REQ-012 SHALL have port: sync  output  1  instruction-cycle marker.
REQ-013 SHALL have port: rom_cmd  output  1  ROM command strobe.
REQ-014 SHALL have port: ram_cmd_n  output  1  RAM command strobe, active-low.
REQ-015 SHALL have port: opr  output  4  opcode upper nibble.
REQ-016 SHALL have port: opa  output  4  opcode lower nibble.
REQ-017 SHALL have port: instr_valid  output  1  one-cycle pulse; opr/opa are fresh.
REQ-018 SHALL have port: second_word  output  1  current cycle fetches the second word.
REQ-019 SHALL have port: phase  output  3  current state encoding.

Function
REQ-020 SHALL implement an 8-state cycle: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7; each state lasts one clock and advances to the next, with X3 going to A1.
REQ-021 In X3 with halt=1, the state SHALL remain X3; with halt=0, it SHALL advance to A1.
REQ-022 On the X3->A1 edge only, the block SHALL latch pc into addr_reg[11:0] and two_word into second_word; stalled X3 cycles SHALL NOT sample pc.
REQ-023 Bus drive in A1/A2/A3: data_o SHALL be addr_reg[3:0], [7:4] and [11:8] respectively, with data_en=1.
REQ-024 Bus capture: the block SHALL release the bus in M1/M2 (data_en=0), capture data_i into opr at the end of M1, and capture data_i into opa at the end of M2.
REQ-025 instr_valid SHALL be 1 for exactly the X1 cycle of every instruction cycle, including second-word cycles.
REQ-026 In X2 with x_drive=1: data_o SHALL be x_data and data_en=1; otherwise data_en=0.
REQ-027 data_en SHALL be 0 in M1, M2, X1 and X3; data_o SHALL be 0 whenever data_en=0.
REQ-028 sync SHALL be 1 in every X3 cycle, including stalled ones, and 0 otherwise.
REQ-029 rom_cmd SHALL be 1 in A3, and in M2 when io_op=1; otherwise 0.
REQ-030 ram_cmd_n SHALL be 0 in X2 when io_op=1 and second_word=0; otherwise 1.
REQ-031 opr and opa SHALL hold their values between captures.
REQ-032 phase SHALL equal the state register, registered with no combinational path from inputs.
REQ-033 Outputs SHALL be Moore-decoded from state plus the listed qualifiers; io_op, x_drive and x_data are the only combinational inputs to outputs.

Reset
REQ-034 While reset=0 at a rising edge, the block SHALL set state=X3, addr_reg=0, opr=0, opa=0 and second_word=0.
REQ-035 Reset SHALL be honoured in any state (mid-cycle abort) and SHALL take precedence over halt.
REQ-036 Outputs during and after reset: sync=1 (state X3), data_en=0, data_o=0, rom_cmd=0, ram_cmd_n=1, instr_valid=0, phase=7.
REQ-037 On the first edge after reset=1 with halt=0, the block SHALL enter A1 with addr_reg=pc.

Verification
REQ-038 The bench SHALL cover nominal fetch: release reset, pc=0xABC, data_i=0x5 in M1 and 0x3 in M2 -> data_o 0xC,0xB,0xA in A1..A3 with data_en=1; opr=5, opa=3; instr_valid high in X1 only; sync high in X3.
REQ-039 The bench SHALL cover halt: halt=1 for 3 X3 cycles with pc changing 0x010->0x020 -> phase=7 for 4 cycles, sync=1 throughout; A1 drives 0x0 from pc=0x020 sampled at exit.
REQ-040 The bench SHALL cover the two-word case: two_word=1 in X3 -> next cycle second_word=1 and instr_valid pulses; io_op=1 in that cycle -> ram_cmd_n stays 1; the following cycle has second_word=0.
REQ-041 The bench SHALL cover I/O strobes: io_op=1 and x_drive=1 with x_data=0x9 -> rom_cmd=1 in A3 and M2; ram_cmd_n=0 in X2 only; data_o=0x9 with data_en=1 in X2.
REQ-042 The bench SHALL cover reset mid-M2: reset=0 in M2 -> next cycle phase=7, opr=0, opa=0, data_en=0, ram_cmd_n=1; opa SHALL NOT capture.
REQ-043 The bench SHALL cover reset during halt: reset=0 while stalled in X3 -> remains X3 with addr_reg=0; on release with halt=0 -> A1 next.
